mem_issue_queue: RTL and testbench

- Reservation station for load/store micro-ops, directly upstream of fu_mem.
- Holds dispatched memory ops until both source operands are ready.
- Wakes operands from the writeback broadcast.
- Selects the oldest ready op each cycle and drives fu_mem's issued/data_in, honouring fu_mem_ready backpressure and mispredict flush.

---
 rtl/mem_issue_queue_pkg.sv | 34 +++
 rtl/memq_oldest_pick.sv | 30 +++
 rtl/mem_issue_queue.sv | 130 +++++++++++++
 tb/tb_mem_issue_queue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_issue_queue_pkg.sv
// Shared types for the memory-op issue queue: op encodings, the dispatched
// op payload, the per-entry record and the ROB age helper.
package mem_issue_queue_pkg;

  localparam int MEMQ_PREG_W = 7;
  localparam int MEMQ_ROB_W  = 5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [6:0]             Opcode;
    logic [MEMQ_PREG_W-1:0] ps1;
    logic [MEMQ_PREG_W-1:0] ps2;
    logic [MEMQ_PREG_W-1:0] pd;
    logic [31:0]            imm;
    logic [MEMQ_ROB_W-1:0]  rob_index;
  } rs_data;

  typedef struct packed {
    logic   valid;
    rs_data data;
    logic   rdy1;
    logic   rdy2;
  } memq_entry_t;

  // Distance from the ROB head; the ROB tag space wraps, so a plain modular
  // subtract gives an ordering where smaller means older.
  function automatic logic [MEMQ_ROB_W-1:0] rob_age(input logic [MEMQ_ROB_W-1:0] tag,
                                                    input logic [MEMQ_ROB_W-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/memq_oldest_pick.sv
// Oldest-eligible picker: scans DEPTH eligible bits and returns the index of
// the one with the smallest age. ROB tags are unique, so ties cannot occur.
module memq_oldest_pick #(
  parameter  int DEPTH = 8,
  parameter  int AGE_W = 5,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            elig_i,
  input  logic [DEPTH-1:0][AGE_W-1:0] age_i,
  output logic                        found_o,
  output logic [IDX_W-1:0]            idx_o
);

  logic [AGE_W-1:0] best;

  // Linear min-age scan over the eligible entries
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    best    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig_i[i] && (!found_o || age_i[i] < best)) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
        best    = age_i[i];
      end
    end
  end

endmodule

// File: rtl/mem_issue_queue.sv
// Reservation station for load/store micro-ops feeding fu_mem. Holds ops
// until their sources are ready (with writeback wakeup), issues the oldest
// ready op under fu_mem backpressure, and squashes younger ops on mispredict.
// Optional: define MEMQ_STORE_ORDER_EN to hold a load while any older store
// is still resident in the queue.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 3,
  parameter int PREG_W = MEMQ_PREG_W,
  parameter int ROB_W  = MEMQ_ROB_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          disp_valid,
  input  rs_data                        disp_data,
  input  logic                          disp_ps1_rdy,
  input  logic                          disp_ps2_rdy,
  output logic                          disp_ready,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB-1:0][PREG_W-1:0] wb_tag,
  input  logic                          fu_mem_ready,
  output logic                          issued,
  output rs_data                        data_out,
  input  logic [ROB_W-1:0]              rob_head,
  input  logic                          mispredict,
  input  logic [ROB_W-1:0]              mispredict_tag
);

  localparam int IDX_W = $clog2(DEPTH);

  memq_entry_t [DEPTH-1:0]            ent_q, ent_d;
  logic        [DEPTH-1:0]            free_vec;
  logic        [DEPTH-1:0]            elig;
  logic        [DEPTH-1:0]            older_st;
  logic        [DEPTH-1:0][ROB_W-1:0] age;
  logic        [IDX_W-1:0]            alloc_idx;
  logic        [IDX_W-1:0]            sel_idx;
  logic                               sel_found;
  logic        [ROB_W-1:0]            flush_age;
  logic                               disp_kill;

  // Source is usable now: tag 0 is hardwired ready, otherwise any writeback hit
  function automatic logic src_wake(input logic [PREG_W-1:0]             tag,
                                    input logic [NUM_WB-1:0]             v,
                                    input logic [NUM_WB-1:0][PREG_W-1:0] t);
    logic h;
    h = (tag == '0);
    for (int w = 0; w < NUM_WB; w++) h = h | (v[w] && t[w] == tag);
    return h;
  endfunction

  // Per-entry ages, free map and lowest free slot
  always_comb begin
    free_vec  = '0;
    alloc_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age[i]      = rob_age(ent_q[i].data.rob_index, rob_head);
      free_vec[i] = !ent_q[i].valid;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IDX_W'(i);
    end
  end

`ifdef MEMQ_STORE_ORDER_EN
  // Flag entries that have an older store still resident ahead of them
  always_comb begin
    older_st = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ent_q[j].valid && ent_q[j].data.Opcode == OP_STORE && age[j] < age[i])
          older_st[i] = 1'b1;
      end
    end
  end
`else
  assign older_st = '0;
`endif

  // Eligibility: loads need only ps1, everything else needs both sources
  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].data.Opcode == OP_LOAD)
        elig[i] = ent_q[i].valid && ent_q[i].rdy1 && !older_st[i];
      else
        elig[i] = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
    end
  end

  memq_oldest_pick #(.DEPTH(DEPTH), .AGE_W(ROB_W)) u_pick (
    .elig_i  (elig),
    .age_i   (age),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  assign disp_ready = |free_vec;
  assign issued     = sel_found && fu_mem_ready && !mispredict;
  assign data_out   = sel_found ? ent_q[sel_idx].data : '0;
  assign flush_age  = rob_age(mispredict_tag, rob_head);
  assign disp_kill  = mispredict && (rob_age(disp_data.rob_index, rob_head) > flush_age);

  // Next entry state: wakeup, dequeue on issue, flush, then allocation
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) begin
        if (src_wake(ent_q[i].data.ps1, wb_valid, wb_tag)) ent_d[i].rdy1 = 1'b1;
        if (src_wake(ent_q[i].data.ps2, wb_valid, wb_tag)) ent_d[i].rdy2 = 1'b1;
        if (issued && sel_idx == IDX_W'(i))                ent_d[i].valid = 1'b0;
        if (mispredict && age[i] > flush_age)              ent_d[i].valid = 1'b0;
      end else if (disp_valid && disp_ready && !disp_kill && alloc_idx == IDX_W'(i)) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].data  = disp_data;
        ent_d[i].rdy1  = disp_ps1_rdy || src_wake(disp_data.ps1, wb_valid, wb_tag);
        ent_d[i].rdy2  = disp_ps2_rdy || src_wake(disp_data.ps2, wb_valid, wb_tag);
      end
    end
  end

  // Entry storage, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ent_q <= '0;
    else        ent_q <= ent_d;
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
`timescale 1ns/1ps
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  localparam int DEPTH  = 8;
  localparam int NUM_WB = 3;
  localparam int PREG_W = MEMQ_PREG_W;
  localparam int ROB_W  = MEMQ_ROB_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic disp_valid = 1'b0, disp_ps1_rdy = 1'b0, disp_ps2_rdy = 1'b0;
  logic fu_mem_ready = 1'b0, mispredict = 1'b0;
  rs_data disp_data = '0;
  logic disp_ready, issued;
  rs_data data_out;
  logic [NUM_WB-1:0] wb_valid = '0;
  logic [NUM_WB-1:0][PREG_W-1:0] wb_tag = '0;
  logic [ROB_W-1:0] rob_head = '0, mispredict_tag = '0;

  always #5 clk = ~clk;

  mem_issue_queue #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .PREG_W(PREG_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_data(disp_data),
    .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .fu_mem_ready(fu_mem_ready), .issued(issued),
    .data_out(data_out), .rob_head(rob_head), .mispredict(mispredict),
    .mispredict_tag(mispredict_tag)
  );

  // Reference model: an unordered list of resident ops
  typedef struct { rs_data d; bit r1; bit r2; } op_t;
  op_t q[$];

  int n_chk = 0, n_fail = 0;
  bit last_iss, last_rdy;
  int last_rob;
  int next_rob;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int age(input logic [ROB_W-1:0] t);
    logic [ROB_W-1:0] a;
    a = t - rob_head;
    return int'(a);
  endfunction

  function automatic bit woken(input logic [PREG_W-1:0] t);
    bit h = (t == 0);
    for (int w = 0; w < NUM_WB; w++) if (wb_valid[w] && wb_tag[w] == t) h = 1;
    return h;
  endfunction

  function automatic bit ok_to_go(input int k);
    bit ld = (q[k].d.Opcode == OP_LOAD);
    bit ok = q[k].r1 && (ld || q[k].r2);
`ifdef MEMQ_STORE_ORDER_EN
    if (ld) foreach (q[j])
      if (q[j].d.Opcode == OP_STORE && age(q[j].d.rob_index) < age(q[k].d.rob_index)) ok = 0;
`endif
    return ok;
  endfunction

  // One cycle: inputs already driven at the negedge; check mid-cycle, then
  // advance the model by what the coming edge should do.
  task automatic step();
    int ci = -1, best = 0, fa;
    bit exp_rdy, exp_iss, add;
    rs_data exp_d;
    op_t n;
    exp_rdy = q.size() < DEPTH;
    foreach (q[k]) if (ok_to_go(k) && (ci < 0 || age(q[k].d.rob_index) < best)) begin
      ci = k; best = age(q[k].d.rob_index);
    end
    exp_iss = (ci >= 0) && fu_mem_ready && !mispredict;
    exp_d = (ci >= 0) ? q[ci].d : '0;
    #2;
    chk("disp_ready", disp_ready, exp_rdy);
    chk("issued", issued, exp_iss);
    chk("data_out", data_out, exp_d);
    last_iss = issued; last_rdy = disp_ready; last_rob = int'(data_out.rob_index);
    fa = age(mispredict_tag);
    add = disp_valid && exp_rdy && !(mispredict && age(disp_data.rob_index) > fa);
    n.d = disp_data;
    n.r1 = disp_ps1_rdy || woken(disp_data.ps1);
    n.r2 = disp_ps2_rdy || woken(disp_data.ps2);
    if (exp_iss) q.delete(ci);
    foreach (q[k]) begin
      if (woken(q[k].d.ps1)) q[k].r1 = 1;
      if (woken(q[k].d.ps2)) q[k].r2 = 1;
    end
    if (mispredict)
      for (int k = q.size() - 1; k >= 0; k--) if (age(q[k].d.rob_index) > fa) q.delete(k);
    if (add) q.push_back(n);
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 0; wb_valid = '0; mispredict = 0;
  endtask

  task automatic disp(input logic [6:0] opc, input int ps1, input bit r1,
                      input int ps2, input bit r2, input int rob);
    disp_data = '0;
    disp_data.Opcode = opc;
    disp_data.ps1 = PREG_W'(ps1);
    disp_data.ps2 = PREG_W'(ps2);
    disp_data.pd  = PREG_W'($urandom_range(1, 127));
    disp_data.imm = $urandom;
    disp_data.rob_index = ROB_W'(rob);
    disp_ps1_rdy = r1; disp_ps2_rdy = r2; disp_valid = 1;
    step();
    disp_valid = 0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_issued", issued, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_disp_ready", disp_ready, 1);
    reset = 1;
    @(negedge clk);

    // Reset mid-stream with three resident ops
    fu_mem_ready = 0;
    disp(OP_STORE, 40, 0, 41, 0, 0);
    disp(OP_STORE, 42, 0, 43, 0, 1);
    disp(OP_LOAD, 44, 1, 0, 1, 2);
    reset = 0;
    #2;
    chk("midrst_issued", issued, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_disp_ready", disp_ready, 1);
    q.delete();
    @(negedge clk);
    reset = 1;
    fu_mem_ready = 1;
    step();
    chk("post_rst_empty", last_iss, 0);

    // Wakeup from writeback port 2
    disp(OP_STORE, 10, 1, 11, 0, 4);
    step();
    wb_valid = 3'b100; wb_tag[2] = 7'd11;
    step();
    chk("wake_edge_no_issue", last_iss, 0);
    idle();
    step();
    chk("wake_issued", last_iss, 1);
    chk("wake_rob", last_rob, 4);

    // Oldest-first across ROB tag wrap
    rob_head = 5'd30; fu_mem_ready = 0;
    disp(OP_LOAD, 3, 1, 0, 1, 1);
    disp(OP_LOAD, 4, 1, 0, 1, 31);
    fu_mem_ready = 1;
    step();
    chk("wrap_first", last_rob, 31);
    step();
    chk("wrap_second", last_rob, 1);
    rob_head = 0;
    step();

    // Backpressure holds the candidate
    fu_mem_ready = 0;
    disp(OP_LOAD, 6, 1, 0, 1, 6);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_held_iss", last_iss, 0);
      chk("bp_held_rob", last_rob, 6);
    end
    fu_mem_ready = 1;
    step();
    chk("bp_release", last_iss, 1);
    step();
    chk("bp_empty", last_iss, 0);

    // Fill, refuse when full, then flush younger than tag 3
    fu_mem_ready = 0;
    for (int r = 0; r < DEPTH; r++) disp(OP_LOAD, r + 1, 1, 0, 1, r);
    disp(OP_LOAD, 9, 1, 0, 1, 8);
    chk("full_refuse", last_rdy, 0);
    fu_mem_ready = 1; mispredict = 1; mispredict_tag = 5'd3;
    step();
    chk("flush_no_issue", last_iss, 0);
    mispredict = 0; fu_mem_ready = 0;
    step();
    chk("flush_ready", last_rdy, 1);
    fu_mem_ready = 1;
    for (int r = 0; r < 4; r++) begin
      step();
      chk("flush_survivor", last_rob, r);
    end
    step();
    chk("flush_drained", last_iss, 0);

    // Store/load ordering
    disp(OP_STORE, 0, 1, 20, 0, 2);
    disp(OP_LOAD, 5, 1, 0, 1, 3);
    step();
`ifdef MEMQ_STORE_ORDER_EN
    chk("order_load_held", last_iss, 0);
`else
    chk("order_load_free", last_rob, 3);
`endif
    wb_valid = 3'b001; wb_tag[0] = 7'd20;
    step();
    idle();
    for (int c = 0; c < 3; c++) step();

    // Randomized traffic against the model
    next_rob = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int span;
      bit ld, acc;
      span = (next_rob - int'(rob_head)) & 31;
      ld = $urandom_range(0, 1);
      disp_data = '0;
      disp_data.Opcode = ld ? OP_LOAD : OP_STORE;
      disp_data.ps1 = PREG_W'($urandom_range(0, 15));
      disp_data.ps2 = PREG_W'($urandom_range(0, 15));
      disp_data.pd  = PREG_W'($urandom_range(0, 127));
      disp_data.imm = $urandom;
      disp_data.rob_index = ROB_W'(next_rob);
      disp_ps1_rdy = ($urandom_range(0, 2) == 0);
      disp_ps2_rdy = ld ? 1'b1 : ($urandom_range(0, 2) == 0);
      disp_valid = (span < 24) && ($urandom_range(0, 2) != 0);
      for (int w = 0; w < NUM_WB; w++) begin
        wb_valid[w] = ($urandom_range(0, 2) == 0);
        wb_tag[w] = PREG_W'($urandom_range(0, 15));
      end
      fu_mem_ready = ($urandom_range(0, 3) != 0);
      mispredict = (span > 0) && ($urandom_range(0, 24) == 0);
      mispredict_tag = ROB_W'(int'(rob_head) + ((span > 0) ? $urandom_range(0, span - 1) : 0));
      acc = disp_valid && (q.size() < DEPTH);
      step();
      if (mispredict) next_rob = (int'(mispredict_tag) + 1) & 31;
      else if (acc) next_rob = (next_rob + 1) & 31;
      if (int'(rob_head) != next_rob && $urandom_range(0, 1) == 1) begin
        bit blk = 0;
        foreach (q[k]) if (q[k].d.rob_index == rob_head) blk = 1;
        if (!blk) rob_head = rob_head + 1'b1;
      end
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
